mem_bus_arbiter: RTL

Shares the single 16-bit memory port between two requesters: the CPU core (instruction/operand/stack traffic) and the chip-I/O/DMA engine. Only one transaction is in flight at a time. The CPU has fixed priority, and a starvation counter guarantees the I/O side eventually wins. Reads return data through a registered, one-cycle rvalid pulse per requester.

---
 rtl/mem_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one memory port between the CPU core and the chip I/O / DMA engine.
// Only one transaction is in flight at a time. The CPU has fixed priority.
// A starvation counter (wait_cnt) lets the I/O side win the next arbitration
// after it has been denied for MAX_WAIT consecutive cycles. Read data comes
// back through a registered rdata and a one-cycle rvalid pulse for each
// requester.
//
// Handshake (the same for both requesters):
//   A requester raises req with rw/addr/wdata and holds all four stable
//   until it sees its gnt pulse. gnt is high in the cycle the memory strobe
//   (mem_en) is issued. The requester may drop req or present a new request
//   in that cycle. Reads complete with a single rvalid pulse. rdata then
//   holds its value until the next read for that requester completes.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cpu_req/rw/addr/wdata            CPU request (rw: 1=read, 0=write)
//   cpu_gnt, cpu_rvalid, cpu_rdata   CPU grant pulse, read-valid pulse, data
//   io_req/rw/addr/wdata             I/O request, same semantics as the CPU
//   io_gnt, io_rvalid, io_rdata      I/O grant pulse, read-valid pulse, data
//   mem_en/rw/addr/wdata             memory strobe and command (held when idle)
//   mem_rdata                        memory read data, valid RD_LAT cycles
//                                    after the mem_en cycle
//   dbg_state                        FSM state (0=IDLE, 1=ISSUE, 2=RDWAIT)
//   dbg_wait_cnt                     current I/O starvation count
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4,
  localparam int WW      = $clog2(MAX_WAIT + 1),
  localparam int LW      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  // CPU requester
  input  logic          cpu_req,
  input  logic          cpu_rw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  // I/O requester
  input  logic          io_req,
  input  logic          io_rw,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] io_wdata,
  output logic          io_gnt,
  output logic          io_rvalid,
  output logic [DW-1:0] io_rdata,
  // Memory port
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // Debug visibility
  output logic [1:0]    dbg_state,
  output logic [WW-1:0] dbg_wait_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [LW-1:0] LAT_INIT = LW'(RD_LAT - 1);

  // Registered state
  state_t        state;
  logic          owner_io;   // 1: the transaction in flight belongs to I/O
  logic [LW-1:0] lat_cnt;
  logic [WW-1:0] wait_cnt;

  // Next-state values
  state_t        state_d;
  logic          owner_io_d;
  logic [LW-1:0] lat_cnt_d;
  logic [WW-1:0] wait_cnt_d;
  logic          mem_en_d;
  logic          mem_rw_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic          cpu_gnt_d;
  logic          io_gnt_d;
  logic          cpu_rvalid_d;
  logic          io_rvalid_d;
  logic [DW-1:0] cpu_rdata_d;
  logic [DW-1:0] io_rdata_d;

  // Arbitration result. Only meaningful in IDLE.
  logic cpu_win;
  logic io_win;

  // ------------------------------------------------------------------------
  // Arbitration. A starved I/O request beats the CPU. Otherwise the CPU has
  // fixed priority.
  // ------------------------------------------------------------------------
  always_comb begin
    cpu_win = 1'b0;
    io_win  = 1'b0;
    if (state == IDLE) begin
      if (io_req && (wait_cnt == WAIT_MAX)) begin
        io_win = 1'b1;
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end else if (io_req) begin
        io_win = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Starvation counter. It counts every cycle in which I/O is requesting but
  // not being granted, including cycles spent serving the CPU. It clears on an
  // I/O grant or whenever I/O stops asking.
  // ------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d = wait_cnt;
    if (io_win) begin
      wait_cnt_d = '0;
    end else if (io_req) begin
      if (wait_cnt != WAIT_MAX) begin
        wait_cnt_d = wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt_d = '0;
    end
  end

  // ------------------------------------------------------------------------
  // FSM next-state and registered outputs
  // ------------------------------------------------------------------------
  always_comb begin
    state_d      = state;
    owner_io_d   = owner_io;
    lat_cnt_d    = lat_cnt;
    mem_en_d     = 1'b0;
    mem_rw_d     = mem_rw;      // command fields hold while the strobe is low
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    cpu_gnt_d    = 1'b0;
    io_gnt_d     = 1'b0;
    cpu_rvalid_d = 1'b0;
    io_rvalid_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata;
    io_rdata_d   = io_rdata;

    unique case (state)
      IDLE: begin
        if (cpu_win || io_win) begin
          state_d     = ISSUE;
          owner_io_d  = io_win;
          mem_en_d    = 1'b1;
          mem_rw_d    = io_win ? io_rw    : cpu_rw;
          mem_addr_d  = io_win ? io_addr  : cpu_addr;
          mem_wdata_d = io_win ? io_wdata : cpu_wdata;
          cpu_gnt_d   = cpu_win;
          io_gnt_d    = io_win;
        end
      end

      ISSUE: begin
        // mem_rw still holds the command issued in this cycle.
        if (mem_rw) begin
          state_d   = RDWAIT;
          lat_cnt_d = LAT_INIT;
        end else begin
          state_d = IDLE;
        end
      end

      RDWAIT: begin
        if (lat_cnt != '0) begin
          lat_cnt_d = lat_cnt - 1'b1;
        end else begin
          // mem_rdata is valid in this cycle. Capture it for the owner, and
          // the owner's rvalid is high in the first IDLE cycle that follows.
          state_d = IDLE;
          if (owner_io) begin
            io_rdata_d  = mem_rdata;
            io_rvalid_d = 1'b1;
          end else begin
            cpu_rdata_d  = mem_rdata;
            cpu_rvalid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Registers. A reset in the middle of a transaction abandons it, and no
  // rvalid is issued for a read that was cut short.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_io   <= 1'b0;
      lat_cnt    <= '0;
      wait_cnt   <= '0;
      mem_en     <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_gnt    <= 1'b0;
      io_gnt     <= 1'b0;
      cpu_rvalid <= 1'b0;
      io_rvalid  <= 1'b0;
      cpu_rdata  <= '0;
      io_rdata   <= '0;
    end else begin
      state      <= state_d;
      owner_io   <= owner_io_d;
      lat_cnt    <= lat_cnt_d;
      wait_cnt   <= wait_cnt_d;
      mem_en     <= mem_en_d;
      mem_rw     <= mem_rw_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      cpu_gnt    <= cpu_gnt_d;
      io_gnt     <= io_gnt_d;
      cpu_rvalid <= cpu_rvalid_d;
      io_rvalid  <= io_rvalid_d;
      cpu_rdata  <= cpu_rdata_d;
      io_rdata   <= io_rdata_d;
    end
  end

  assign dbg_state    = state;
  assign dbg_wait_cnt = wait_cnt;

  // ------------------------------------------------------------------------
  // Structural invariants
  // ------------------------------------------------------------------------
  a_one_gnt : assert property (@(posedge clk) disable iff (rst)
    !(cpu_gnt && io_gnt));

  a_one_rvalid : assert property (@(posedge clk) disable iff (rst)
    !(cpu_rvalid && io_rvalid));

  a_gnt_with_strobe : assert property (@(posedge clk) disable iff (rst)
    (cpu_gnt || io_gnt) == mem_en);

  a_strobe_single : assert property (@(posedge clk) disable iff (rst)
    mem_en |=> !mem_en);

endmodule
